// File: rtl/reg_write_arbiter.sv
// Register write arbiter: merges buffered I2C target writes and internal
// (sleep/restart) writes into one registered register-storage write port.
// ALL_LED ids (0xFA..0xFD) are forwarded unchanged and then expanded into
// sixteen per-LED writes before the arbiter grants anything else.
module reg_write_arbiter #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       i2c_we_i,
   input  logic [7:0] i2c_id_i,
   input  logic [7:0] i2c_value_i,
   input  logic       int_valid_i,
   input  logic [7:0] int_id_i,
   input  logic [7:0] int_value_i,
   output logic       int_ready_o,
   output logic       wr_en_o,
   output logic [7:0] wr_id_o,
   output logic [7:0] wr_value_o,
   output logic       busy_o,
   output logic       overflow_o,
   input  logic       clear_overflow_i
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      IDLE,
      EXPAND
   } state_t;

   state_t state;
   state_t next_state;

   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic             drop;

   logic             last_int;
   logic             grant_i2c;
   logic             grant_int;

   logic [7:0]       head_id;
   logic [7:0]       head_value;
   logic [7:0]       sel_id;
   logic [7:0]       sel_value;
   logic             sel_all_led;

   logic [3:0]       exp_index;
   logic [3:0]       next_exp_index;
   logic [1:0]       exp_offset;
   logic [7:0]       exp_value;
   logic             load_expand;

   logic             issue;
   logic [7:0]       issue_id;
   logic [7:0]       issue_value;

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == DEPTH_C);
   assign head_id     = fifo_mem[rd_ptr][15:8];
   assign head_value  = fifo_mem[rd_ptr][7:0];

   assign sel_id      = grant_int ? int_id_i    : head_id;
   assign sel_value   = grant_int ? int_value_i : head_value;
   assign sel_all_led = (sel_id >= 8'hFA) && (sel_id <= 8'hFD);

   assign pop  = grant_i2c;
   assign push = i2c_we_i && !rst_i && (!fifo_full || pop);
   assign drop = i2c_we_i && !rst_i && fifo_full && !pop;

   assign int_ready_o = grant_int;
   assign busy_o      = !fifo_empty || (state != IDLE) || wr_en_o;

   // Round-robin grant between the FIFO head and the internal requester; the
   // loser of a tie is whichever side was granted most recently.
   always_comb begin
      grant_i2c = 1'b0;
      grant_int = 1'b0;
      if (!rst_i && state == IDLE) begin
         if (!fifo_empty && (!int_valid_i || last_int)) begin
            grant_i2c = 1'b1;
         end else if (int_valid_i) begin
            grant_int = 1'b1;
         end
      end
   end

   // Next-state and write-issue decode: IDLE forwards the granted write, an
   // ALL_LED grant arms EXPAND, and EXPAND walks the sixteen LED registers.
   always_comb begin
      next_state     = state;
      next_exp_index = exp_index;
      load_expand    = 1'b0;
      issue          = 1'b0;
      issue_id       = wr_id_o;
      issue_value    = wr_value_o;
      case (state)
         IDLE: begin
            if (grant_i2c || grant_int) begin
               issue       = 1'b1;
               issue_id    = sel_id;
               issue_value = sel_value;
               if (sel_all_led) begin
                  next_state     = EXPAND;
                  next_exp_index = 4'd0;
                  load_expand    = 1'b1;
               end
            end
         end
         EXPAND: begin
            issue          = 1'b1;
            issue_id       = 8'h06 + {2'b00, exp_index, 2'b00} + {6'b000000, exp_offset};
            issue_value    = exp_value;
            next_exp_index = exp_index + 4'd1;
            if (exp_index == 4'd15) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register plus the captured ALL_LED channel offset and value.
   // The offset is id-0xFA modulo 4, which only needs the low two id bits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         exp_index  <= 4'd0;
         exp_offset <= 2'd0;
         exp_value  <= 8'h00;
      end else begin
         state     <= next_state;
         exp_index <= next_exp_index;
         if (load_expand) begin
            exp_offset <= sel_id[1:0] - 2'b10;
            exp_value  <= sel_value;
         end
      end
   end

   // Remember which side won last so ties alternate; internal after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_int <= 1'b1;
      end else if (grant_i2c) begin
         last_int <= 1'b0;
      end else if (grant_int) begin
         last_int <= 1'b1;
      end
   end

   // Registered write port; id and value hold when no write is issued.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_en_o    <= 1'b0;
         wr_id_o    <= 8'h00;
         wr_value_o <= 8'h00;
      end else begin
         wr_en_o    <= issue;
         wr_id_o    <= issue_id;
         wr_value_o <= issue_value;
      end
   end

   // FIFO storage; contents need no reset because the count guards reads.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {i2c_id_i, i2c_value_i};
      end
   end

   // FIFO pointers and occupancy; a full FIFO may accept a push when popped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky drop flag; a new drop beats a simultaneous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (clear_overflow_i) begin
         overflow_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a queue-based reference model
// predicts every register write (with its output cycle) plus busy, overflow
// and int_ready; an independent monitor checks each wr_en_o cycle.
module tb_reg_write_arbiter;

   localparam int DEPTH = 4;

   logic       clk_i;
   logic       rst_i;
   logic       i2c_we_i;
   logic [7:0] i2c_id_i;
   logic [7:0] i2c_value_i;
   logic       int_valid_i;
   logic [7:0] int_id_i;
   logic [7:0] int_value_i;
   logic       int_ready_o;
   logic       wr_en_o;
   logic [7:0] wr_id_o;
   logic [7:0] wr_value_o;
   logic       busy_o;
   logic       overflow_o;
   logic       clear_overflow_i;

   typedef struct {
      int         cyc;
      logic [7:0] id;
      logic [7:0] value;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model_fifo[$];
   logic [15:0] model_expand[$];
   bit          model_last_int;
   bit          model_ovf;
   bit          model_busy;
   bit          int_pend;
   logic [7:0]  int_id_cur;
   logic [7:0]  int_val_cur;
   int          checks;
   int          fails;
   int          cycle;

   reg_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .i2c_we_i         (i2c_we_i),
      .i2c_id_i         (i2c_id_i),
      .i2c_value_i      (i2c_value_i),
      .int_valid_i      (int_valid_i),
      .int_id_i         (int_id_i),
      .int_value_i      (int_value_i),
      .int_ready_o      (int_ready_o),
      .wr_en_o          (wr_en_o),
      .wr_id_o          (wr_id_o),
      .wr_value_o       (wr_value_o),
      .busy_o           (busy_o),
      .overflow_o       (overflow_o),
      .clear_overflow_i (clear_overflow_i)
   );

   // Free-running clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks = checks + 1;
      if (actual != expected) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Monitor: every posedge, compare any presented write with the scoreboard
   // head, and flag writes the model expected but the DUT never produced.
   always @(posedge clk_i) begin
      exp_t e;
      cycle = cycle + 1;
      #1;
      if (wr_en_o) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_write", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("write_cycle", cycle, e.cyc);
            checkOutput("write_id", wr_id_o, e.id);
            checkOutput("write_value", wr_value_o, e.value);
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cycle) begin
         e = sb.pop_front();
         checkOutput("missing_write", 0, 1);
      end
   end

   function automatic logic [7:0] randId();
      case ($urandom_range(0, 9))
         0:       return 8'hFA + 8'($urandom_range(0, 3));
         1:       return 8'hFE;
         2:       return 8'hFF;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic setInt(input logic [7:0] id, input logic [7:0] value);
      int_pend    = 1'b1;
      int_id_cur  = id;
      int_val_cur = value;
   endtask

   // Reference model for one clock: arbitration in IDLE, pending ALL_LED
   // expansion writes otherwise, then the FIFO push/drop rule.
   task automatic modelStep(input bit we, input logic [7:0] id, input logic [7:0] value, input bit clr);
      logic [15:0] w;
      bit idle, fifo_req, int_req, g_i2c, g_int, wrote, drop;
      idle     = (model_expand.size() == 0);
      fifo_req = idle && (model_fifo.size() != 0);
      int_req  = idle && int_pend;
      g_i2c    = fifo_req && (!int_req || model_last_int);
      g_int    = int_req && !g_i2c;
      checkOutput("int_ready", int_ready_o, g_int);
      wrote = 1'b0;
      drop  = 1'b0;
      if (!idle) begin
         w = model_expand.pop_front();
         sb.push_back(exp_t'{cycle + 1, w[15:8], w[7:0]});
         wrote = 1'b1;
      end else if (g_i2c || g_int) begin
         if (g_i2c) begin
            w = model_fifo.pop_front();
         end else begin
            w = {int_id_cur, int_val_cur};
            int_pend = 1'b0;
         end
         model_last_int = g_int;
         sb.push_back(exp_t'{cycle + 1, w[15:8], w[7:0]});
         wrote = 1'b1;
         if (w[15:8] >= 8'hFA && w[15:8] <= 8'hFD) begin
            for (int n = 0; n < 16; n++) begin
               model_expand.push_back({8'h06 + 8'(4 * n) + (w[15:8] - 8'hFA), w[7:0]});
            end
         end
      end
      if (we) begin
         if (model_fifo.size() < DEPTH) model_fifo.push_back({id, value});
         else drop = 1'b1;
      end
      if (drop) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
      model_busy = (model_fifo.size() != 0) || (model_expand.size() != 0) || wrote;
   endtask

   task automatic applyStimulus(input bit we, input logic [7:0] id, input logic [7:0] value, input bit clr);
      @(negedge clk_i);
      checkOutput("busy", busy_o, model_busy);
      checkOutput("overflow", overflow_o, model_ovf);
      i2c_we_i         = we;
      i2c_id_i         = id;
      i2c_value_i      = value;
      clear_overflow_i = clr;
      int_valid_i      = int_pend;
      int_id_i         = int_id_cur;
      int_value_i      = int_val_cur;
      #1;
      modelStep(we, id, value, clr);
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   // Asserts reset with live request inputs, checks the immediate clear,
   // then releases with quiet inputs.
   task automatic doReset();
      @(negedge clk_i);
      rst_i       = 1'b1;
      i2c_we_i    = 1'b1;
      i2c_id_i    = 8'h42;
      i2c_value_i = 8'h24;
      int_valid_i = 1'b1;
      int_id_i    = 8'h01;
      int_value_i = 8'h02;
      #1;
      checkOutput("reset_wr_en", wr_en_o, 0);
      checkOutput("reset_wr_id", wr_id_o, 0);
      checkOutput("reset_wr_value", wr_value_o, 0);
      checkOutput("reset_busy", busy_o, 0);
      checkOutput("reset_overflow", overflow_o, 0);
      checkOutput("reset_int_ready", int_ready_o, 0);
      sb.delete();
      model_fifo.delete();
      model_expand.delete();
      model_last_int = 1'b1;
      model_ovf      = 1'b0;
      model_busy     = 1'b0;
      int_pend       = 1'b0;
      @(negedge clk_i);
      i2c_we_i         = 1'b0;
      int_valid_i      = 1'b0;
      clear_overflow_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Directed scenarios followed by a randomized run and a drain.
   initial begin
      bit we;
      int loaded;
      checks = 0;
      fails  = 0;
      cycle  = 0;
      rst_i = 1'b1;
      i2c_we_i = 1'b0;
      i2c_id_i = 8'h00;
      i2c_value_i = 8'h00;
      int_valid_i = 1'b0;
      int_id_i = 8'h00;
      int_value_i = 8'h00;
      clear_overflow_i = 1'b0;
      int_pend = 1'b0;
      int_id_cur = 8'h00;
      int_val_cur = 8'h00;
      model_last_int = 1'b1;
      model_ovf = 1'b0;
      model_busy = 1'b0;

      doReset();

      $display("[TB] round robin with both requesters pending");
      applyStimulus(1'b1, 8'h10, 8'h01, 1'b0);
      setInt(8'h00, 8'h11);
      applyStimulus(1'b1, 8'h11, 8'h02, 1'b0);
      loaded = 0;
      for (int k = 0; k < 6; k++) begin
         if (!int_pend && loaded == 0) begin
            setInt(8'h00, 8'h91);
            loaded = 1;
         end
         applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      end
      idleCycles(3);

      $display("[TB] single I2C write");
      applyStimulus(1'b1, 8'h06, 8'h55, 1'b0);
      idleCycles(4);

      $display("[TB] ALL_LED expansion with internal request waiting");
      applyStimulus(1'b1, 8'hFC, 8'hAA, 1'b0);
      for (int k = 0; k < 24; k++) begin
         if (k == 2) setInt(8'h07, 8'h3C);
         applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      end

      $display("[TB] FIFO overflow during expansion");
      applyStimulus(1'b1, 8'hFA, 8'h0F, 1'b0);
      idleCycles(1);
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'h20 + 8'(k), 8'h30 + 8'(k), 1'b0);
      idleCycles(25);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
      idleCycles(2);

      $display("[TB] push and pop on a full FIFO");
      applyStimulus(1'b1, 8'hFB, 8'h5A, 1'b0);
      for (int k = 0; k < 30; k++) begin
         we = (k < 4) || (model_expand.size() == 0);
         applyStimulus(we, 8'h40 + 8'(k), 8'h80 + 8'(k), 1'b0);
      end
      idleCycles(10);

      $display("[TB] reset in the middle of an expansion");
      applyStimulus(1'b1, 8'hFD, 8'h33, 1'b0);
      idleCycles(6);
      doReset();
      idleCycles(5);

      $display("[TB] randomized traffic");
      for (int k = 0; k < 400; k++) begin
         if (!int_pend && $urandom_range(0, 3) == 0) setInt(randId(), 8'($urandom));
         applyStimulus($urandom_range(0, 2) == 0, randId(), 8'($urandom),
                       $urandom_range(0, 19) == 0);
      end
      idleCycles(60);
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of I2C write entries buffered (power of two, 2..16).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port i2c_we_i, input, 1 bit: one-cycle write pulse from the I2C target, with no backpressure.
REQ-005 SHALL have port i2c_id_i, input, 8 bits: I2C target register id, valid with i2c_we_i.
REQ-006 SHALL have port i2c_value_i, input, 8 bits: I2C target register value, valid with i2c_we_i.
REQ-007 SHALL have port int_valid_i, input, 1 bit: internal requester (sleep/restart logic) write request.
REQ-008 SHALL have port int_id_i, input, 8 bits: internal request register id.
REQ-009 SHALL have port int_value_i, input, 8 bits: internal request register value.
REQ-010 SHALL have port int_ready_o, output, 1 bit: internal request accepted this cycle when int_valid_i is also high.
REQ-011 SHALL have port wr_en_o, output, 1 bit: register-storage write strobe, registered.
REQ-012 SHALL have port wr_id_o, output, 8 bits: register-storage write id, registered.
REQ-013 SHALL have port wr_value_o, output, 8 bits: register-storage write value, registered.
REQ-014 SHALL have port busy_o, output, 1 bit: high when the FIFO is non-empty, state is not IDLE, or wr_en_o is high.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky flag meaning an I2C write was dropped.
REQ-016 SHALL have port clear_overflow_i, input, 1 bit: clears overflow_o.

Function
REQ-017 SHALL push {i2c_id_i, i2c_value_i} into the FIFO on i2c_we_i when count<FIFO_DEPTH, or when the FIFO is full and popped in the same cycle.
REQ-018 SHALL drop an I2C write arriving when full without a simultaneous pop, and set overflow_o on the next edge; a set in the same cycle as clear_overflow_i wins.
REQ-019 SHALL have states IDLE and EXPAND; grants occur only in IDLE.
REQ-020 In IDLE, candidates SHALL be "FIFO non-empty" and int_valid_i; with one candidate, grant it; with both, grant the one not granted last (round robin).
REQ-021 SHALL treat last-grant as internal after reset, so I2C wins the first tie.
REQ-022 SHALL drive int_ready_o combinationally high only in IDLE when the internal requester would be granted; an internal transfer is int_valid_i & int_ready_o.
REQ-023 A granted write SHALL appear on wr_en_o/wr_id_o/wr_value_o one cycle after grant; back-to-back grants give one write per cycle.
REQ-024 A granted id in 0xFA..0xFD (ALL_LED) SHALL be issued unchanged, then state SHALL enter EXPAND.
REQ-025 In EXPAND, SHALL issue 16 consecutive writes with id 0x06+4*n+(id-0xFA), n=0..15 ascending, with the same value, then return to IDLE.
REQ-026 An ALL_LED grant SHALL produce exactly 17 consecutive wr_en_o cycles; the next grant SHALL be allowed in the cycle the 17th write is output.
REQ-027 During EXPAND: no grants, int_ready_o=0, FIFO pushes continue per REQ-017.
REQ-028 When not writing, wr_en_o SHALL be 0; wr_id_o/wr_value_o SHALL hold their last values.
REQ-029 All id arithmetic SHALL be 8-bit; ids outside 0xFA..0xFD pass through unmodified, including 0xFE and 0xFF.

Reset
REQ-030 rst_i high SHALL immediately clear: FIFO empty, state IDLE, last-grant internal, wr_en_o=0, wr_id_o=0, wr_value_o=0, overflow_o=0, int_ready_o=0, busy_o=0.
REQ-031 rst_i asserted mid-EXPAND SHALL abandon the remaining expansion writes; none SHALL be issued after release.
REQ-032 SHALL accept no push or grant while rst_i is high.

Verification
REQ-033 Single I2C pulse id 0x06 value 0x55 -> wr_en_o for one cycle, 2 cycles after the pulse, with 0x06/0x55.
REQ-034 Both requesters pending continuously (FIFO 0x10/0x01,0x11/0x02; int 0x00/0x11 then 0x00/0x91) -> grants alternate I2C, int, I2C, int.
REQ-035 I2C write id 0xFC value 0xAA -> 17 consecutive writes: 0xFC, then 0x08, 0x0C, ... 0x44, all 0xAA; int_ready_o low throughout EXPAND.
REQ-036 Six I2C pulses while EXPAND blocks draining (FIFO_DEPTH=4) -> four later written in order, two dropped, overflow_o=1 until clear_overflow_i.
REQ-037 rst_i pulse after the 5th expansion write -> outputs zero immediately, no further writes, busy_o=0.
REQ-038 Full FIFO with a push and pop in the same cycle -> push accepted, overflow_o stays 0.
